timer_share_arb: RTL and testbench
==================================

Name: timer_share_arb

Overview:
- Shares one pattern-triggered countdown timer among NUM_REQ requesters.
- The timer has a serial data input, a count/counting/done output group and an ack input. It expects the start pattern 1101, then a 4-bit delay MSB first, and counts (delay+1)*1000 cycles.
- This block arbitrates requesters round-robin, serializes the winner's delay onto the timer data line, routes timer status back to the winner, and completes the done/ack handshake on its behalf.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DELAY_W, 4, delay field width; fixed by the timer protocol
- WDOG_LIMIT, 16064, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- req  in  NUM_REQ  per-requester service request (level)
- req_delay  in  NUM_REQ*DELAY_W  packed delay per requester; requester i uses bits [i*4+:4]
- req_ack  in  NUM_REQ  requester acknowledges its done_o
- grant  out  NUM_REQ  one-hot; held for the whole service
- done_o  out  NUM_REQ  timer finished for the granted requester; held until req_ack
- counting_o  out  NUM_REQ  tmr_counting gated by grant
- count_o  out  4  tmr_count passthrough (valid while counting)
- tmr_data  out  1  serial pattern/delay to the timer
- tmr_ack  out  1  ack to the timer
- tmr_counting  in  1  from timer
- tmr_done  in  1  from timer
- tmr_count  in  4  from timer

Behaviour:
- Reset values: grant=0, done_o=0, tmr_data=0, tmr_ack=0, state IDLE, rr pointer=0, bit index=0. All outputs are registered except counting_o and count_o.
- States: IDLE, SEND, WAIT_DONE, WAIT_ACK, RELEASE.
- IDLE:
  - tmr_data=0.
  - If any req is high, pick the first set bit at or after the rr pointer (wrapping), register its one-hot grant, snapshot its req_delay, go to SEND.
  - The grant is visible one cycle after req is sampled.
- SEND:
  - Drive 8 bits, one per cycle, MSB first: 1,1,0,1,d3,d2,d1,d0.
  - The first SEND cycle coincides with the first grant cycle.
  - After bit index 7, go to WAIT_DONE.
- WAIT_DONE:
  - tmr_data=0.
  - When tmr_done=1, set done_o[winner]=1 and go to WAIT_ACK.
- WAIT_ACK:
  - Hold done_o until req_ack[winner]=1.
  - Then clear done_o, set tmr_ack=1 and go to RELEASE.
  - req_ack from non-granted requesters is ignored.
- RELEASE:
  - tmr_ack is high for exactly this one cycle.
  - grant clears at the exit of RELEASE; rr pointer = winner+1 (mod NUM_REQ); go to IDLE.
  - Minimum 1 IDLE cycle between services, with tmr_data=0 so the timer cannot see a false pattern.
- Request withdrawn mid-service (req drops after grant): ignored; the service completes normally.
- req_delay changing after grant: ignored (snapshot is used).
- delay=0 is legal and gives a 1000-cycle count. delay=15 gives 16000 cycles.
- Reset mid-service: immediate return to IDLE with all outputs at reset values. The timer shares the same reset.
- tmr_done outside WAIT_DONE is ignored.

Optional Feature:
- Macro: TIMER_SHARE_ARB_WDOG_EN
- With the macro:
  - A 15-bit counter runs in WAIT_DONE.
  - If it reaches WDOG_LIMIT before tmr_done, the block asserts output wdog_err (1-cycle pulse) and sets done_o[winner]. The flow then proceeds through WAIT_ACK/RELEASE as normal, so tmr_ack resyncs the timer.
  - The counter clears on every entry to WAIT_DONE.
- Without the macro: no wdog_err port, no counter; WAIT_DONE waits indefinitely.

Decomposition:
- Package timer_share_pkg holds:
  - the state enum;
  - the constant START_PATTERN=4'b1101;
  - SEND_BITS=8;
  - the default WDOG_LIMIT.
- One sub-module, rr_arbiter: parameterised NUM_REQ, inputs req and ptr, output one-hot gnt. It is combinational and reused elsewhere.

Test Plan:
- Single request:
  - Stimulus: req[0]=1, delay=4'h2.
  - Required: grant=0001 next cycle; tmr_data=1,1,0,1,0,0,1,0 over 8 cycles, then 0.
  - Then: with timer done, done_o[0]=1.
  - Then: req_ack[0] gives exactly one cycle of tmr_ack and grant=0.
- Round-robin:
  - Stimulus: req=0101 after reset.
  - Required: serve 0 then 2.
  - Then: re-request 0101 immediately after 2's release; 0 is served next.
  - Next: req=1111 continuously; required grant order 0,1,2,3,0.
- Withdrawal:
  - Stimulus: drop req[1] and change req_delay[1] two cycles into SEND.
  - Required: the original delay bits are still shifted; the service completes.
- Ack discipline:
  - Stimulus: done_o[1]=1; assert req_ack[3] for 5 cycles, then req_ack[1].
  - Required: done_o[1] holds through the req_ack[3] cycles; tmr_ack fires only after req_ack[1].
- Reset mid-count:
  - Stimulus: assert reset during WAIT_DONE with counting_o=0100.
  - Required: next cycle grant=0, done_o=0, tmr_data=0, tmr_ack=0.
  - Then: a new req is served starting from requester 0.
- Watchdog (TIMER_SHARE_ARB_WDOG_EN):
  - Stimulus: hold tmr_done=0, WDOG_LIMIT=100.
  - Required: wdog_err pulses at cycle 100 of WAIT_DONE; done_o[winner]=1.

Source files
------------

// File: rtl/timer_share_pkg.sv
// Shared types and constants for the pattern-triggered timer sharing arbiter.
package timer_share_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_DONE,
    ST_WAIT_ACK,
    ST_RELEASE
  } state_e;

  localparam logic [3:0] START_PATTERN      = 4'b1101;
  localparam int         SEND_BITS          = 8;
  localparam int         WDOG_LIMIT_DEFAULT = 16064;

endpackage

// File: rtl/timer_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_share_arb.sv
// Shares one pattern-triggered countdown timer among NUM_REQ requesters.
// Optional watchdog on the done wait: define TIMER_SHARE_ARB_WDOG_EN.
module timer_share_arb
  import timer_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DELAY_W = 4
`ifdef TIMER_SHARE_ARB_WDOG_EN
  , parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
  input  logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done_o,
  output logic [NUM_REQ-1:0]         counting_o,
  output logic [3:0]                 count_o,
  output logic                       tmr_data,
  output logic                       tmr_ack,
  input  logic                       tmr_counting,
  input  logic                       tmr_done,
  input  logic [3:0]                 tmr_count
`ifdef TIMER_SHARE_ARB_WDOG_EN
  , output logic                     wdog_err
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d, arb_gnt;
  logic [IDX_W-1:0]     ptr_q, ptr_d, win_q, win_d, sel_idx;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DELAY_W-1:0]   delay_q, delay_d;
  logic                 tmr_data_q, tmr_data_d, tmr_ack_q, tmr_ack_d;
  logic [DELAY_W-1:0]   delay_arr [NUM_REQ];
  logic [SEND_BITS-1:0] frame;
`ifdef TIMER_SHARE_ARB_WDOG_EN
  logic [14:0]          wdog_cnt_q, wdog_cnt_d;
  logic                 wdog_err_q, wdog_err_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_delay
      assign delay_arr[gi] = req_delay[gi*DELAY_W +: DELAY_W];
    end
  endgenerate

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(IDX_W)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_idx = IDX_W'(i);
    end
  end

  assign frame = {START_PATTERN, delay_q};

  // tmr_data is registered, so each bit is computed one cycle ahead of bit_idx_q.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = done_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    bit_idx_d  = bit_idx_q;
    delay_d    = delay_q;
    tmr_data_d = 1'b0;
    tmr_ack_d  = 1'b0;
`ifdef TIMER_SHARE_ARB_WDOG_EN
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d    = arb_gnt;
          win_d      = sel_idx;
          delay_d    = delay_arr[sel_idx];
          bit_idx_d  = '0;
          tmr_data_d = START_PATTERN[3];
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_idx_q == 3'(SEND_BITS-1)) begin
          bit_idx_d = '0;
          state_d   = ST_WAIT_DONE;
`ifdef TIMER_SHARE_ARB_WDOG_EN
          wdog_cnt_d = '0;
`endif
        end else begin
          bit_idx_d  = bit_idx_q + 3'd1;
          tmr_data_d = frame[3'(SEND_BITS-2) - bit_idx_q];
        end
      end
      ST_WAIT_DONE: begin
        if (tmr_done) begin
          done_d  = grant_q;
          state_d = ST_WAIT_ACK;
        end
`ifdef TIMER_SHARE_ARB_WDOG_EN
        else if (wdog_cnt_q == 15'(WDOG_LIMIT-1)) begin
          done_d     = grant_q;
          wdog_err_d = 1'b1;
          state_d    = ST_WAIT_ACK;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 15'd1;
        end
`endif
      end
      ST_WAIT_ACK: begin
        if (|(req_ack & grant_q)) begin
          done_d    = '0;
          tmr_ack_d = 1'b1;
          state_d   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        grant_d = '0;
        ptr_d   = (win_q == IDX_W'(NUM_REQ-1)) ? '0 : win_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
      bit_idx_q  <= '0;
      delay_q    <= '0;
      tmr_data_q <= 1'b0;
      tmr_ack_q  <= 1'b0;
`ifdef TIMER_SHARE_ARB_WDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      bit_idx_q  <= bit_idx_d;
      delay_q    <= delay_d;
      tmr_data_q <= tmr_data_d;
      tmr_ack_q  <= tmr_ack_d;
`ifdef TIMER_SHARE_ARB_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign done_o     = done_q;
  assign tmr_data   = tmr_data_q;
  assign tmr_ack    = tmr_ack_q;
  assign counting_o = grant_q & {NUM_REQ{tmr_counting}};
  assign count_o    = tmr_count;
`ifdef TIMER_SHARE_ARB_WDOG_EN
  assign wdog_err   = wdog_err_q;
`endif

endmodule

// File: tb/tb_timer_share_arb.sv
// Directed self-checking bench for timer_share_arb; the timer is driven by hand.
module tb_timer_share_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_ack, grant, done_o, counting_o;
  logic [N*4-1:0] req_delay;
  logic [3:0]    count_o, tmr_count;
  logic          tmr_data, tmr_ack, tmr_counting, tmr_done;
`ifdef TIMER_SHARE_ARB_WDOG_EN
  logic          wdog_err;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Delays per requester as loaded by req_delay = 16'h9A52.
  logic [3:0] dtab [4] = '{4'h2, 4'h5, 4'hA, 4'h9};

  always #5 clk = ~clk;

  timer_share_arb #(
    .NUM_REQ (N),
    .DELAY_W (4)
`ifdef TIMER_SHARE_ARB_WDOG_EN
    , .WDOG_LIMIT (100)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_delay    (req_delay),
    .req_ack      (req_ack),
    .grant        (grant),
    .done_o       (done_o),
    .counting_o   (counting_o),
    .count_o      (count_o),
    .tmr_data     (tmr_data),
    .tmr_ack      (tmr_ack),
    .tmr_counting (tmr_counting),
    .tmr_done     (tmr_done),
    .tmr_count    (tmr_count)
`ifdef TIMER_SHARE_ARB_WDOG_EN
    , .wdog_err   (wdog_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h need %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_ack = '0; tmr_done = 1'b0; tmr_counting = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Expects a grant on the next edge and the 8-bit frame on tmr_data from that cycle on.
  task automatic expect_send(input logic [3:0] exp_gnt, input logic [3:0] dly,
                             input int withdraw_at, input bit noise);
    logic [7:0] frame;
    frame = {4'b1101, dly};
    if (noise) tmr_done = 1'b1;
    step();
    check("grant", grant, exp_gnt);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      if (i == withdraw_at) begin
        req = '0;
        req_delay = ~req_delay;
      end
      check($sformatf("data%0d", i), tmr_data, frame[7-i]);
    end
    step();
    tmr_done = 1'b0;
    check("data_after", tmr_data, 1'b0);
    check("grant_hold", grant, exp_gnt);
    if (noise) begin
      step();
      check("done_noise", done_o, 4'b0000);
    end
  endtask

  task automatic ack_service(input int who, input int bad_cycles);
    logic [3:0] oh;
    oh = 4'(1 << who);
    if (bad_cycles > 0) req_ack = 4'(1 << ((who + 2) % 4));
    for (int i = 0; i < bad_cycles; i++) begin
      step();
      check("done_hold", done_o, oh);
      check("ack_early", tmr_ack, 1'b0);
    end
    req_ack = oh;
    step();
    req_ack = '0;
    check("tmr_ack", tmr_ack, 1'b1);
    check("done_clr", done_o, 4'b0000);
    step();
    check("tmr_ack_pulse", tmr_ack, 1'b0);
    check("grant_clr", grant, 4'b0000);
    $display("service req%0d complete, grant released", who);
  endtask

  task automatic finish_service(input int who, input int bad_cycles);
    logic [3:0] oh;
    oh = 4'(1 << who);
    tmr_counting = 1'b1;
    tmr_count = 4'(who + 3);
    #1;
    check("counting", counting_o, oh);
    check("count", count_o, who + 3);
    tmr_counting = 1'b0;
    tmr_done = 1'b1;
    step();
    tmr_done = 1'b0;
    check("done", done_o, oh);
    ack_service(who, bad_cycles);
  endtask

  initial begin
    int k;
    reset = 1'b1; req = '0; req_delay = '0; req_ack = '0;
    tmr_done = 1'b0; tmr_counting = 1'b0; tmr_count = '0;
    step();
    step();
    check("rst_grant", grant, 4'b0000);
    check("rst_done", done_o, 4'b0000);
    check("rst_data", tmr_data, 1'b0);
    check("rst_ack", tmr_ack, 1'b0);
    reset = 1'b0;

    // Single request, stray tmr_done during SEND must be ignored.
    req = 4'b0001; req_delay = 16'h0002;
    expect_send(4'b0001, 4'h2, -1, 1'b1);
    req = '0;
    finish_service(0, 0);

    // Round robin with 0101, then immediate re-request.
    do_reset();
    req_delay = 16'h9A52;
    req = 4'b0101;
    expect_send(4'b0001, 4'h2, -1, 1'b0); finish_service(0, 0);
    expect_send(4'b0100, 4'hA, -1, 1'b0); finish_service(2, 0);
    expect_send(4'b0001, 4'h2, -1, 1'b0); finish_service(0, 0);

    // Continuous 1111: order 0,1,2,3,0.
    do_reset();
    req_delay = 16'h9A52;
    req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      expect_send(4'(1 << (s % 4)), dtab[s % 4], -1, 1'b0);
      finish_service(s % 4, 0);
    end
    req = '0;

    // Withdrawal plus foreign req_ack while done_o[1] is pending.
    req_delay = 16'h9A52;
    req = 4'b0010;
    expect_send(4'b0010, 4'h5, 2, 1'b0);
    finish_service(1, 5);
    req_delay = 16'h9A52;

    // Reset during WAIT_DONE, then service restarts from requester 0.
    req = 4'b0100;
    expect_send(4'b0100, 4'hA, -1, 1'b0);
    tmr_counting = 1'b1;
    #1;
    check("counting_mid", counting_o, 4'b0100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tmr_counting = 1'b0;
    check("mid_grant", grant, 4'b0000);
    check("mid_done", done_o, 4'b0000);
    check("mid_data", tmr_data, 1'b0);
    check("mid_ack", tmr_ack, 1'b0);
    req = 4'b1111;
    expect_send(4'b0001, 4'h2, -1, 1'b0);
    req = '0;
    finish_service(0, 0);

`ifdef TIMER_SHARE_ARB_WDOG_EN
    req = 4'b0010;
    expect_send(4'b0010, 4'h5, -1, 1'b0);
    req = '0;
    k = 0;
    while (wdog_err !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check("wdog_cycle", k, 100);
    check("wdog_done", done_o, 4'b0010);
    step();
    check("wdog_pulse", wdog_err, 1'b0);
    ack_service(1, 0);
`else
    k = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
